alu_op_sequencer: RTL and testbench

//   Sequences one ALU instruction through the relay ALU: decodes the 8-bit ALU opcode
//   (1000_r_fff), drives the 3-bit function code to the 3-to-8 function decoder, and

---
 rtl/alu_op_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Runs one ALU-class instruction (8'b1000_r_fff) through the relay ALU.
//   The function code is presented to the 3-to-8 function decoder with the
//   output enable raised. Both are held for SETTLE_CYCLES so the relays can
//   settle. The result is then strobed into A (r=0) or D (r=1), the S/C/Z
//   condition flags are updated, and a completion pulse goes back to the
//   instruction sequencer.
//
//   Optional feature macro: HPRC_ALU_FLAGS_EN
//     defined   : S/C/Z flag register is built and updated on LATCH.
//     undefined : no flag storage; flags reads 3'b000; timing unchanged.
//
// Parameters
//   SETTLE_CYCLES  cycles alu_fn/alu_en are held before the result is taken (>=1)
//   CNT_W          settle counter width; must be able to hold SETTLE_CYCLES
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   instr_valid  in   instruction offered
//   instr_ready  out  sequencer can accept (IDLE only)
//   instr        in   [7:4]=1000 ALU class, [3]=dest (0=A,1=D), [2:0]=fn
//   alu_fn       out  function code to the decoder (000 when idle)
//   alu_en       out  ALU output enable onto the data bus
//   alu_result   in   ALU output bus
//   alu_carry    in   adder carry-out / SHL shifted-out bit
//   load_a       out  one-cycle load strobe for register A
//   load_d       out  one-cycle load strobe for register D
//   flags        out  {S,C,Z} condition register
//   done         out  one-cycle completion pulse
//   illegal      out  one-cycle pulse when a non-ALU opcode is offered
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr,
    output logic [2:0] alu_fn,
    output logic       alu_en,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic       load_a,
    output logic       load_d,
    output logic [2:0] flags,
    output logic       done,
    output logic       illegal
);

    localparam int unsigned FN_W = 3;

    localparam logic [3:0]      ALU_CLASS = 4'b1000;
    localparam logic [FN_W-1:0] FN_ADD    = 3'b000;
    localparam logic [FN_W-1:0] FN_INC    = 3'b001;
    localparam logic [FN_W-1:0] FN_SHL    = 3'b110;
    localparam logic [FN_W-1:0] FN_NULL   = 3'b111;

    // Counter preload: SETTLE state lasts SETTLE_CYCLES cycles, ending at zero.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    // Reject configurations the settle counter cannot represent.
    if ((SETTLE_CYCLES < 1) ||
        (64'(SETTLE_CYCLES) > ((64'(1) << CNT_W) - 64'(1)))) begin : g_bad_cfg
        $error("alu_op_sequencer: SETTLE_CYCLES=%0d does not fit CNT_W=%0d (or is < 1)",
               SETTLE_CYCLES, CNT_W);
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LATCH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dest;

    logic             is_alu_class;
    logic             fn_writes;

    // Decode helpers: opcode class on the offered instruction, and whether the
    // latched function produces a result (NULL runs the timing but writes nothing).
    assign is_alu_class = (instr[7:4] == ALU_CLASS);
    assign fn_writes    = (alu_fn != FN_NULL);

`ifdef HPRC_ALU_FLAGS_EN
    logic             carry_fn;
    logic [2:0]       flags_next;

    // Carry only has meaning for the adder paths and the shifter.
    assign carry_fn   = (alu_fn == FN_ADD) || (alu_fn == FN_INC) || (alu_fn == FN_SHL);
    assign flags_next = {alu_result[7], carry_fn & alu_carry, (alu_result == 8'h00)};
`else
    // No flag storage: the result/carry inputs only feed the external registers.
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{alu_result, alu_carry};
    assign flags              = 3'b000;
`endif

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            dest        <= 1'b0;
            instr_ready <= 1'b0;
            alu_fn      <= FN_ADD;
            alu_en      <= 1'b0;
            load_a      <= 1'b0;
            load_d      <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
`ifdef HPRC_ALU_FLAGS_EN
            flags       <= 3'b000;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            load_a  <= 1'b0;
            load_d  <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!instr_ready) begin
                        // First cycle after reset: open for business.
                        instr_ready <= 1'b1;
                    end else if (instr_valid) begin
                        if (is_alu_class) begin
                            state       <= ST_SETTLE;
                            instr_ready <= 1'b0;
                            dest        <= instr[3];
                            alu_fn      <= instr[2:0];
                            alu_en      <= 1'b1;
                            cnt         <= CNT_LOAD;
                        end else begin
                            // Stay ready; only the illegal pulse moves.
                            illegal <= 1'b1;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state  <= ST_LATCH;
                        load_a <= fn_writes & ~dest;
                        load_d <= fn_writes & dest;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_LATCH: begin
                    // Result is taken on this edge by the target register.
                    state  <= ST_DONE;
                    alu_en <= 1'b0;
                    alu_fn <= FN_ADD;
                    done   <= 1'b1;
`ifdef HPRC_ALU_FLAGS_EN
                    if (fn_writes) begin
                        flags <= flags_next;
                    end
`endif
                end

                ST_DONE: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b1;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Directed scenarios followed by randomized instruction traffic. Expected
//   outputs per cycle come from the instruction's accept time and its decoded
//   fields; the flag register is tracked as a plain model variable.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [2:0] alu_fn;
    logic       alu_en;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       load_a;
    logic       load_d;
    logic [2:0] flags;
    logic       done;
    logic       illegal;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] mflags;

    alu_op_sequencer #(
        .SETTLE_CYCLES(S),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_fn     (alu_fn),
        .alu_en     (alu_en),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .load_a     (load_a),
        .load_d     (load_d),
        .flags      (flags),
        .done       (done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ph, input logic en, input logic [2:0] fn,
                                 input logic la, input logic ld, input logic dn,
                                 input logic il, input logic rdy, input logic [2:0] fl);
        chk({ph, ".alu_en"},      8'(alu_en),      8'(en));
        chk({ph, ".alu_fn"},      8'(alu_fn),      8'(fn));
        chk({ph, ".load_a"},      8'(load_a),      8'(la));
        chk({ph, ".load_d"},      8'(load_d),      8'(ld));
        chk({ph, ".done"},        8'(done),        8'(dn));
        chk({ph, ".illegal"},     8'(illegal),     8'(il));
        chk({ph, ".instr_ready"}, 8'(instr_ready), 8'(rdy));
        chk({ph, ".flags"},       8'(flags),       8'(fl));
    endtask

    // Flag value an operation leaves behind, from the arithmetic definition.
    function automatic logic [2:0] new_flags(input logic [2:0] fn, input logic [7:0] res,
                                             input logic c);
`ifdef HPRC_ALU_FLAGS_EN
        logic s, cf, z;
        s  = res[7];
        cf = (fn == 3'd0 || fn == 3'd1 || fn == 3'd6) ? c : 1'b0;
        z  = (res == 8'h00);
        return {s, cf, z};
`else
        return 3'b000;
`endif
    endfunction

    // Wait (bounded) for instr_ready, sampling on the falling edge.
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 8'(instr_ready), 8'd1);
    endtask

    // Offer one instruction and check every cycle until the sequencer is ready again.
    task automatic do_op(input string nm, input logic [7:0] ins, input logic [7:0] res,
                         input logic c, input bit keep_valid);
        logic [2:0] fn;
        logic       dest;
        logic       isop;
        wait_ready();
        instr       = ins;
        instr_valid = 1'b1;
        alu_result  = res;
        alu_carry   = c;
        @(posedge clk); #1;
        if (ins[7:4] != 4'b1000) begin
            instr_valid = 1'b0;
            check_outputs({nm, ".ill"}, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, mflags);
            @(posedge clk); #1;
            check_outputs({nm, ".ill_after"}, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mflags);
            return;
        end
        fn   = ins[2:0];
        dest = ins[3];
        isop = (fn != 3'b111);
        for (int k = 1; k <= int'(S) + 3; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k == 1) begin
                // While busy, a held-valid garbage opcode must be ignored.
                if (keep_valid) instr = 8'($urandom);
                else            instr_valid = 1'b0;
            end
            if (k == int'(S) + 2 && isop) mflags = new_flags(fn, res, c);
            check_outputs($sformatf("%s.k%0d", nm, k),
                          k <= int'(S) + 1,
                          (k <= int'(S) + 1) ? fn : 3'd0,
                          (k == int'(S) + 1) && !dest && isop,
                          (k == int'(S) + 1) && dest && isop,
                          k == int'(S) + 2,
                          1'b0,
                          k == int'(S) + 3,
                          mflags);
        end
    endtask

    // Start an ALU op and assert rst during cycle T+at; nothing of it may complete.
    task automatic do_abort(input string nm, input logic [7:0] ins, input int at);
        wait_ready();
        instr       = ins;
        instr_valid = 1'b1;
        alu_result  = 8'h00;
        alu_carry   = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (int k = 2; k <= at; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        mflags = 3'b000;
        check_outputs({nm, ".rst"}, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_outputs({nm, ".rec"}, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    endtask

    initial begin
        logic [7:0] ins;
        int         r;

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 8'h00;
        alu_result  = 8'h00;
        alu_carry   = 1'b0;
        mflags      = 3'b000;

        // Reset state and ready one cycle after release.
        @(posedge clk);
        @(posedge clk); #1;
        check_outputs("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_outputs("post_reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);

        // ADD->A with zero result and carry, then NULL keeps flags, then XOR->D.
        do_op("add_a",  8'h80, 8'h00, 1'b1, 1'b0);
        do_op("null",   8'h87, 8'h5A, 1'b1, 1'b0);
        do_op("xor_d",  8'h8C, 8'hA5, 1'b1, 1'b0);
        // Non-ALU opcode.
        do_op("illeg",  8'h40, 8'h00, 1'b0, 1'b0);
        // Abort mid-SETTLE, then a normal INC->A.
        do_op("pre_ab", 8'h80, 8'h00, 1'b1, 1'b0);
        do_abort("abort", 8'h80, 3);
        do_op("inc_a",  8'h81, 8'h80, 1'b1, 1'b0);
        // Back-to-back with valid held and instr changing mid-SETTLE.
        do_op("b2b_1",  8'h8E, 8'hC0, 1'b1, 1'b1);
        do_op("b2b_2",  8'h82, 8'h00, 1'b1, 1'b1);
        do_op("b2b_3",  8'h8D, 8'h01, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 120; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                ins = 8'($urandom);
                if (ins[7:4] == 4'b1000) ins[7:4] = 4'b1001;
                do_op($sformatf("rnd%0d_ill", i), ins, 8'($urandom), 1'($urandom), 1'b0);
            end else if (r == 1) begin
                ins = {4'b1000, 4'($urandom)};
                do_abort($sformatf("rnd%0d_ab", i), ins, int'($urandom_range(1, S + 1)));
            end else begin
                ins = {4'b1000, 4'($urandom)};
                do_op($sformatf("rnd%0d", i), ins, 8'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        instr_valid = 1'b0;
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
